instr_encoder: RTL and testbench
================================

# instr_encoder

Pipelined RISC-V RV32I instruction encoder: the inverse of the decode-stage control unit. It accepts decoded instruction fields (operation class, ALU control, memory op, branch type, register indices, immediate) over a valid/ready handshake. It emits the 32-bit instruction word, paired with a word-aligned instruction-memory address, over a second valid/ready handshake. It is used by the test harness and boot loader to build programs in instruction memory directly from control-field descriptions.

## Interface
- ADDR_WIDTH, 32: width of out_addr; the address counter wraps modulo 2^ADDR_WIDTH.
- BASE_ADDR, 0: value loaded into the address counter on reset and on clear.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  reloads the address counter to BASE_ADDR and drops any held output word
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept fields this cycle
- in_class  in  4  op_class_t: R, I_ARITH, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC
- in_alu  in  4  ALU control code: add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001
- in_memop  in  3  memory op: b 000, h 001, w 010, bu 011, hu 100
- in_branch  in  3  branch type: beq 001, bne 010, blt 011, bge 100, bltu 101, bgeu 110
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed byte-offset immediate; for U types, the full upper value (bits 11:0 ignored)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts the word
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_WIDTH  address of out_word
- err  out  1  sticky illegal-field flag
- err_count  out  8  count of rejected inputs; saturates at 255

## Operation
- The field-to-funct3/funct7 mapping is fixed as follows:
  - ALU codes: add/sub f3 0; sll 1; slt 2; sltu 3; xor 4; srl/sra 5; or 6; and 7.
  - funct7 is 0x20 for sub and sra, 0x00 otherwise.
  - Loads: memop b/h/w/bu/hu map to f3 0/1/2/4/5.
  - Stores: memop b/h/w map to f3 0/1/2.
  - Branches: beq/bne/blt/bge/bltu/bgeu map to f3 0/1/4/5/6/7.
- Fixed field encodings per class:
  - I_ARITH sll/srl/sra use in_imm[4:0] as shamt, with funct7 in bits 31:25.
  - JALR uses f3 0.
  - B and J immediates use the standard scattered bit layout; bit 0 is dropped.
- An input is illegal in any of these cases; it is consumed but not emitted:
  - I_ARITH with sub.
  - ALU code above 1001.
  - LOAD memop above 100.
  - STORE memop above 010.
  - BRANCH type 000 or 111.
  - Undefined class.
- On an illegal input: err is set, err_count increments, and out_addr does not advance.
- The address counter advances by 4 on each output handshake (out_valid && out_ready) and wraps silently.
- Encode is a combinational function of the registered input; the output stage is a single register slice.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0.
  - out_word = 0.
  - out_addr = BASE_ADDR.
  - err = 0.
  - err_count = 0.
- Latency: fields accepted on edge N appear on out_word with out_valid high after edge N, i.e. 1 cycle later.
- in_ready = !out_valid || out_ready, giving full throughput: one word per cycle under continuous out_ready.
- While out_valid && !out_ready, out_word and out_addr are held stable.
- clear has priority over a simultaneous handshake:
  - out_valid drops and the address counter reloads.
  - An input accepted in the same cycle is discarded.
  - err and err_count are unaffected.
- rst mid-transfer discards the held word with no partial output.
- err is cleared only by rst.

## Configuration
- INSTR_ENCODER_IMM_CHECK_EN defined:
  - Immediates out of range are treated as illegal inputs.
  - Ranges: I/S/JALR signed 12-bit; B signed 13-bit and even; J signed 21-bit and even; shamt imm[31:5] == 0.
- Undefined: immediates are silently truncated to the encodable bits.

## Structure
- Shared package riscv_pkg holds:
  - op_class_t.
  - Opcode constants: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - ALU, memop and branch code constants, shared with the control unit.
- One sub-module, instr_encode_comb: pure combinational fields-to-{word, illegal} function, instantiated between the input and output registers.

## Test plan
- I_ARITH add, rd=1, rs1=0, imm=5 -> out_word 0x00500093 at out_addr BASE_ADDR, one cycle after acceptance.
- R sub, rd=3, rs1=1, rs2=2 -> 0x402081B3; next word at BASE_ADDR+4.
- LUI rd=5, imm=0x12345000 -> 0x123452B7.
- BRANCH beq, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3.
- out_ready held low for 3 cycles with a word pending -> word and address stable, in_ready low; out_ready high -> exactly one handshake.
- I_ARITH sub -> no out_valid, err=1, err_count=1, address unchanged.
- With the macro defined, addi imm=4096 -> rejected; without it -> 0x00000093.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I control-field definitions: operation classes, opcodes, and
// ALU/memory/branch codes common to the decoder and the encoder.
package riscv_pkg;

  typedef enum logic [3:0] {
    ClsR      = 4'd0,
    ClsIArith = 4'd1,
    ClsLoad   = 4'd2,
    ClsStore  = 4'd3,
    ClsBranch = 4'd4,
    ClsJal    = 4'd5,
    ClsJalr   = 4'd6,
    ClsLui    = 4'd7,
    ClsAuipc  = 4'd8
  } op_class_t;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSll  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluSlt  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;

  localparam logic [2:0] MemB  = 3'b000;
  localparam logic [2:0] MemH  = 3'b001;
  localparam logic [2:0] MemW  = 3'b010;
  localparam logic [2:0] MemBu = 3'b011;
  localparam logic [2:0] MemHu = 3'b100;

  localparam logic [2:0] BrBeq  = 3'b001;
  localparam logic [2:0] BrBne  = 3'b010;
  localparam logic [2:0] BrBlt  = 3'b011;
  localparam logic [2:0] BrBge  = 3'b100;
  localparam logic [2:0] BrBltu = 3'b101;
  localparam logic [2:0] BrBgeu = 3'b110;

endpackage

// File: rtl/instr_encode_comb.sv
// Pure combinational mapping from decoded control fields to an RV32I word plus
// an illegal flag. INSTR_ENCODER_IMM_CHECK_EN adds immediate range checking.
module instr_encode_comb
  import riscv_pkg::*;
(
  input  logic [3:0]  i_class,
  input  logic [3:0]  i_alu,
  input  logic [2:0]  i_memop,
  input  logic [2:0]  i_branch,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic [2:0] w_alu_f3;
  logic [2:0] w_ld_f3;
  logic [2:0] w_br_f3;
  logic [6:0] w_f7;
  logic       w_shift;
  logic       w_fld_bad;

  assign w_f7    = ((i_alu == AluSub) || (i_alu == AluSra)) ? 7'h20 : 7'h00;
  assign w_shift = (i_alu == AluSll) || (i_alu == AluSrl) || (i_alu == AluSra);

  always_comb begin
    case (i_alu)
      AluAdd, AluSub: w_alu_f3 = 3'd0;
      AluSll:         w_alu_f3 = 3'd1;
      AluSlt:         w_alu_f3 = 3'd2;
      AluSltu:        w_alu_f3 = 3'd3;
      AluXor:         w_alu_f3 = 3'd4;
      AluSrl, AluSra: w_alu_f3 = 3'd5;
      AluOr:          w_alu_f3 = 3'd6;
      default:        w_alu_f3 = 3'd7;
    endcase
    case (i_memop)
      MemB:    w_ld_f3 = 3'd0;
      MemH:    w_ld_f3 = 3'd1;
      MemW:    w_ld_f3 = 3'd2;
      MemBu:   w_ld_f3 = 3'd4;
      default: w_ld_f3 = 3'd5;
    endcase
    case (i_branch)
      BrBne:   w_br_f3 = 3'd1;
      BrBlt:   w_br_f3 = 3'd4;
      BrBge:   w_br_f3 = 3'd5;
      BrBltu:  w_br_f3 = 3'd6;
      BrBgeu:  w_br_f3 = 3'd7;
      default: w_br_f3 = 3'd0;
    endcase
  end

  always_comb begin
    o_word    = '0;
    w_fld_bad = 1'b0;
    case (i_class)
      ClsR: begin
        w_fld_bad = i_alu > AluSltu;
        o_word    = {w_f7, i_rs2, i_rs1, w_alu_f3, i_rd, OpR};
      end
      ClsIArith: begin
        w_fld_bad = (i_alu > AluSltu) || (i_alu == AluSub);
        o_word    = w_shift ? {w_f7, i_imm[4:0], i_rs1, w_alu_f3, i_rd, OpImm}
                            : {i_imm[11:0], i_rs1, w_alu_f3, i_rd, OpImm};
      end
      ClsLoad: begin
        w_fld_bad = i_memop > MemHu;
        o_word    = {i_imm[11:0], i_rs1, w_ld_f3, i_rd, OpLoad};
      end
      ClsStore: begin
        w_fld_bad = i_memop > MemW;
        o_word    = {i_imm[11:5], i_rs2, i_rs1, i_memop, i_imm[4:0], OpStore};
      end
      ClsBranch: begin
        w_fld_bad = (i_branch == 3'b000) || (i_branch == 3'b111);
        o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_br_f3, i_imm[4:1], i_imm[11],
                     OpBranch};
      end
      ClsJal:   o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OpJal};
      ClsJalr:  o_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, OpJalr};
      ClsLui:   o_word = {i_imm[31:12], i_rd, OpLui};
      ClsAuipc: o_word = {i_imm[31:12], i_rd, OpAuipc};
      default:  w_fld_bad = 1'b1;
    endcase
  end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  logic w_imm_bad;

  function automatic logic fits_signed(logic [31:0] v, int unsigned bits);
    return ($signed(v) >= -(32'sd1 <<< (bits - 1))) && ($signed(v) < (32'sd1 <<< (bits - 1)));
  endfunction

  always_comb begin
    w_imm_bad = 1'b0;
    case (i_class)
      ClsIArith: w_imm_bad = w_shift ? (i_imm[31:5] != '0) : !fits_signed(i_imm, 12);
      ClsLoad, ClsStore, ClsJalr: w_imm_bad = !fits_signed(i_imm, 12);
      ClsBranch: w_imm_bad = !fits_signed(i_imm, 13) || i_imm[0];
      ClsJal:    w_imm_bad = !fits_signed(i_imm, 21) || i_imm[0];
      default:   w_imm_bad = 1'b0;
    endcase
  end

  assign o_illegal = w_fld_bad | w_imm_bad;
`else
  assign o_illegal = w_fld_bad;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: fields in over valid/ready, {word, address} out of a
// single register slice. Build with INSTR_ENCODER_IMM_CHECK_EN to reject wide immediates.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_class,
  input  logic [3:0]            in_alu,
  input  logic [2:0]            in_memop,
  input  logic [2:0]            in_branch,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_word,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err,
  output logic [7:0]            err_count
);

  logic [31:0]           w_word;
  logic                  w_illegal;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  r_valid;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_err;
  logic [7:0]            r_err_count;

  instr_encode_comb u_encode (
    .i_class   (in_class),
    .i_alu     (in_alu),
    .i_memop   (in_memop),
    .i_branch  (in_branch),
    .i_rd      (in_rd),
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_valid && out_ready;

  // clear wins over both handshakes; the accepted input is dropped without side effects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_word      <= '0;
      r_addr      <= BASE_ADDR;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_addr  <= BASE_ADDR;
    end else begin
      if (w_out_hs) begin
        r_valid <= 1'b0;
        r_addr  <= r_addr + ADDR_WIDTH'(4);
      end
      if (w_in_hs) begin
        if (!w_illegal) begin
          r_valid <= 1'b1;
          r_word  <= w_word;
        end else begin
          r_err <= 1'b1;
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_word  = r_word;
  assign out_addr  = r_addr;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized traffic
// against a field-arithmetic reference model and a transaction-level state model.
module tb_instr_encoder;
  import riscv_pkg::*;

  localparam int unsigned AW   = 32;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]  in_class, in_alu;
  logic [2:0]  in_memop, in_branch;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_word, out_addr;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_alu    (in_alu),
    .in_memop  (in_memop),
    .in_branch (in_branch),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .err       (err),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected observable state, advanced one transaction step at a time.
  logic        m_valid;
  logic [31:0] m_word;
  logic [31:0] m_addr;
  logic        m_err;
  int          m_cnt;

  logic [31:0] alu_f3 [16] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3, 0, 0, 0, 0, 0, 0};
  logic [31:0] ld_f3  [8]  = '{0, 1, 2, 4, 5, 0, 0, 0};
  logic [31:0] br_f3  [8]  = '{0, 0, 1, 4, 5, 6, 7, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [31:0] f7, rs2, rs1, f3, rd, op);
    return ((f7 & 32'd127) << 25) | ((rs2 & 32'd31) << 20) | ((rs1 & 32'd31) << 15) |
           ((f3 & 32'd7) << 12) | ((rd & 32'd31) << 7) | (op & 32'd127);
  endfunction

  function automatic logic sfit(input logic [31:0] v, input int bits);
    int s;
    s = $signed(v);
    return (s >= -(1 <<< (bits - 1))) && (s < (1 <<< (bits - 1)));
  endfunction

  // Returns {illegal, word} from the instruction-format rules.
  function automatic logic [32:0] ref_enc(input logic [3:0] c, input logic [3:0] alu,
      input logic [2:0] mop, input logic [2:0] br, input logic [4:0] rd, rs1, rs2,
      input logic [31:0] imm);
    logic [31:0] a, f7, w, u;
    logic        bad, rng;
    a   = 32'(alu);
    f7  = (a == 1 || a == 7) ? 32'd32 : 32'd0;
    bad = 1'b0;
    rng = 1'b0;
    w   = '0;
    case (c)
      4'd0: begin
        bad = a > 9;
        w   = pack(f7, 32'(rs2), 32'(rs1), alu_f3[alu], 32'(rd), 32'h33);
      end
      4'd1: begin
        bad = a > 9 || a == 1;
        if (a >= 5 && a <= 7) begin
          w   = pack(f7, imm, 32'(rs1), alu_f3[alu], 32'(rd), 32'h13);
          rng = (imm >> 5) != 0;
        end else begin
          w   = pack(imm >> 5, imm, 32'(rs1), alu_f3[alu], 32'(rd), 32'h13);
          rng = !sfit(imm, 12);
        end
      end
      4'd2: begin
        bad = mop > 4;
        rng = !sfit(imm, 12);
        w   = pack(imm >> 5, imm, 32'(rs1), ld_f3[mop], 32'(rd), 32'h03);
      end
      4'd3: begin
        bad = mop > 2;
        rng = !sfit(imm, 12);
        w   = pack(imm >> 5, 32'(rs2), 32'(rs1), 32'(mop), imm, 32'h23);
      end
      4'd4: begin
        bad = br == 0 || br == 7;
        rng = !sfit(imm, 13) || imm[0];
        w   = pack((((imm >> 12) & 1) << 6) | ((imm >> 5) & 63), 32'(rs2), 32'(rs1),
                   br_f3[br], (imm & 30) | ((imm >> 11) & 1), 32'h63);
      end
      4'd5: begin
        rng = !sfit(imm, 21) || imm[0];
        u   = (((imm >> 20) & 1) << 19) | (((imm >> 1) & 1023) << 9) |
              (((imm >> 11) & 1) << 8) | ((imm >> 12) & 255);
        w   = (u << 12) | (32'(rd) << 7) | 32'h6F;
      end
      4'd6: begin
        rng = !sfit(imm, 12);
        w   = pack(imm >> 5, imm, 32'(rs1), 0, 32'(rd), 32'h67);
      end
      4'd7: w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h37;
      4'd8: w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h17;
      default: bad = 1'b1;
    endcase
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    bad = bad | rng;
`endif
    return {bad, w};
  endfunction

  task automatic set_fields(input int c, alu, mop, br, rd, rs1, rs2, input logic [31:0] imm);
    in_class  = 4'(c);
    in_alu    = 4'(alu);
    in_memop  = 3'(mop);
    in_branch = 3'(br);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
  endtask

  // Called at a negedge: drive, predict the coming edge, then compare at the next negedge.
  task automatic step(input logic v, input logic ordy, input logic clr);
    logic [32:0] r;
    logic        acc, hs;
    in_valid  = v;
    out_ready = ordy;
    clear     = clr;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    r   = ref_enc(in_class, in_alu, in_memop, in_branch, in_rd, in_rs1, in_rs2, in_imm);
    acc = v && (!m_valid || ordy);
    hs  = m_valid && ordy;
    if (clr) begin
      m_valid = 1'b0;
      m_addr  = BASE;
    end else begin
      if (hs) begin
        m_valid = 1'b0;
        m_addr  = m_addr + 32'd4;
      end
      if (acc) begin
        if (!r[32]) begin
          m_valid = 1'b1;
          m_word  = r[31:0];
        end else begin
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_word", out_word, m_word);
      check("out_addr", out_addr, m_addr);
    end
    check("err", 32'(err), 32'(m_err));
    check("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
    @(negedge clk);
    m_valid = 1'b0;
    m_word  = '0;
    m_addr  = BASE;
    m_err   = 1'b0;
    m_cnt   = 0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    set_fields(0, 0, 0, 1, 0, 0, 0, 32'd0);
    @(negedge clk);
    do_reset();

    set_fields(1, 0, 0, 1, 1, 0, 0, 32'd5);
    step(1'b1, 1'b1, 1'b0);
    check("addi_word", out_word, 32'h0050_0093);
    check("addi_addr", out_addr, BASE);

    set_fields(0, 1, 0, 1, 3, 1, 2, 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("sub_word", out_word, 32'h4020_81B3);
    check("sub_addr", out_addr, BASE + 32'd4);

    set_fields(7, 0, 0, 1, 5, 0, 0, 32'h1234_5000);
    step(1'b1, 1'b1, 1'b0);
    check("lui_word", out_word, 32'h1234_52B7);

    set_fields(4, 0, 0, 1, 0, 1, 2, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0);
    check("beq_word", out_word, 32'hFE20_8EE3);

    // Back-pressure: the beq word must hold while a new input waits.
    set_fields(1, 0, 0, 1, 2, 2, 0, 32'd7);
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0);
      check("stall_word", out_word, 32'hFE20_8EE3);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0);
    check("one_hs_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("wrap_addr", out_addr, 32'd0);
    step(1'b0, 1'b1, 1'b0);

    set_fields(1, 1, 0, 1, 4, 4, 0, 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check("ill_valid", 32'(out_valid), 32'd0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_count", 32'(err_count), 32'd1);
    check("ill_addr", out_addr, 32'd4);

    set_fields(1, 0, 0, 1, 1, 0, 0, 32'd4096);
    step(1'b1, 1'b1, 1'b0);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    check("imm4096_rej", 32'(out_valid), 32'd0);
`else
    check("imm4096_word", out_word, 32'h0000_0093);
`endif

    // Clear with a pending word and a simultaneous legal input.
    set_fields(7, 0, 0, 1, 6, 0, 0, 32'hABCD_E000);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_addr", out_addr, BASE);
    check("clr_err", 32'(err), 32'd1);

    for (int i = 0; i < 400; i++) begin
      int          c, k;
      logic [31:0] imm;
      logic        v, clr;
      c = $urandom_range(0, 9);
      if (c == 9) c = $urandom_range(9, 15);
      k = $urandom_range(0, 3);
      imm = (k == 0) ? $urandom() :
            (k == 1) ? 32'($urandom_range(0, 4095)) - 32'd2048 :
            (k == 2) ? 32'($urandom_range(0, 31)) : (32'($urandom_range(0, 2047)) << 1);
      set_fields(c, $urandom_range(0, 11), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
      v   = $urandom_range(0, 9) < 7;
      clr = !v && ($urandom_range(0, 49) == 0);
      step(v, $urandom_range(0, 9) < 7, clr);
    end

    set_fields(15, 0, 0, 1, 0, 0, 0, 32'd0);
    for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 1'b0);
    check("sat_count", 32'(err_count), 32'd255);

    // Reset while a word is held.
    set_fields(8, 0, 0, 1, 9, 0, 0, 32'h0000_1000);
    step(1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset();
    step(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
